// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/muldiv_core.sv
// Unsigned magnitude engine: one shift-add or restoring shift-subtract step per cycle.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Multiply keeps {acc_hi,acc_lo} as partial product / remaining multiplier;
    // divide keeps acc_hi as partial remainder and shifts quotient bits into acc_lo.
    always_comb begin
        sum     = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            opnd   <= b_mag;
            count  <= '0;
        end else if (step) begin
            count <= count + 1'b1;
            if (is_div) begin
                acc_hi <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc_hi <= sum[WIDTH:1];
                acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    assign last   = (count == CW'(WIDTH - 1));
    assign res_hi = acc_hi;
    assign res_lo = acc_lo;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS multiply/divide unit: FSM, sign handling, HI/LO registers and MTHI/MTLO writes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wordIn,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state_q, state_d;
    op_e              op_q;
    logic             sa_q, sb_q, bzero_q;
    logic             load, step, fix, last;
    logic             signed_in;
    logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo;
    logic [2*WIDTH-1:0] fixed;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Signed multiply negates the whole product; signed divide negates the quotient
    // on differing signs and gives the remainder the dividend's sign.
    function automatic logic [2*WIDTH-1:0] sign_fix(input op_e o, input logic sa,
                                                    input logic sb,
                                                    input logic [WIDTH-1:0] rh,
                                                    input logic [WIDTH-1:0] rl);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   q, r;
        prod = {rh, rl};
        q    = rl;
        r    = rh;
        case (o)
            OP_MULT:  return (sa ^ sb) ? -prod : prod;
            OP_DIV: begin
                if (sa ^ sb) q = -q;
                if (sa)      r = -r;
                return {r, q};
            end
            default:  return prod;
        endcase
    endfunction

    assign signed_in = ~op[0];
    assign a_mag     = magnitude(a, signed_in);
    assign b_mag     = magnitude(b, signed_in);
    assign fixed     = sign_fix(op_q, sa_q, sb_q, res_hi, res_lo);
    assign busy      = (state_q != S_IDLE);

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .load   (load),
        .step   (step),
        .is_div (op_q[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                load    = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                step = 1'b1;
                if (last) state_d = S_FIX;
            end
            S_FIX: begin
                fix     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load) begin
            op_q    <= op_e'(op);
            sa_q    <= signed_in & a[WIDTH-1];
            sb_q    <= signed_in & b[WIDTH-1];
            bzero_q <= (b == '0);
        end
    end

    // MTHI/MTLO only land when the unit is idle and no operation is being launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state_q     <= state_d;
            done        <= fix;
            div_by_zero <= fix & op_q[1] & bzero_q;
            if (fix) begin
                if (!(op_q[1] && bzero_q)) begin
                    hi <= fixed[2*WIDTH-1:WIDTH];
                    lo <= fixed[WIDTH-1:0];
                end
            end else if (state_q == S_IDLE && !start) begin
                if (hi_write) hi <= wordIn;
                if (lo_write) lo <= wordIn;
            end
        end
    end

endmodule
